logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Round-robin arbiter and sequencer that shares one bitwise logic unit (AND/OR/XOR/NAND over WIDTH-bit operands) among NUM_REQ requesters. It grants one requester at a time, captures that requester's operands and opcode, and evaluates them in a registered stage. It then returns the result with the requester's index over a valid/ready response port. It sits between the client blocks and the shared gate datapath, so there is no per-client replicated logic.

## Interface
- WIDTH, 2: operand and result width in bits (1..32).
- NUM_REQ, 4: number of requesters (2..8); IDW = $clog2(NUM_REQ).
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request; held high until the matching gnt bit is seen.
- op_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- op_b  input  NUM_REQ*WIDTH  operand B, same packing as op_a.
- op_sel  input  NUM_REQ*2  opcode per requester, [i*2 +: 2]: 00 AND, 01 OR, 10 XOR, 11 NAND.
- gnt  output  NUM_REQ  one-hot, single-cycle grant pulse.
- res_valid  output  1  result available.
- res_data  output  WIDTH  result of the granted operation.
- res_id  output  IDW  index of the requester that owns res_data.
- res_ready  input  1  consumer accepts the result when res_valid && res_ready.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req is nonzero at a rising edge, select the winner by round-robin. The search starts at pointer rr_ptr and increases modulo NUM_REQ.
  - On that same edge, capture the winner's op_a, op_b and op_sel, plus the winner index.
  - Set rr_ptr to (winner+1) mod NUM_REQ. Index NUM_REQ-1 wraps to 0.
  - Go to EXEC.
  - If req is zero, stay in IDLE; rr_ptr is unchanged.
- EXEC:
  - gnt[winner] is high for exactly this cycle.
  - The bitwise function is applied to the captured operands.
  - At the next edge, register res_data and res_id, set res_valid=1, and go to RESP.
- RESP:
  - res_valid, res_data and res_id are held stable until res_valid && res_ready at an edge.
  - On that edge, clear res_valid and go to IDLE.
- Arbitration happens only in IDLE. req changes during EXEC or RESP have no effect.
- A req withdrawn before it is sampled in IDLE is never granted. This is legal.
- Operands are sampled only on the IDLE capture edge. Later changes on op_a, op_b or op_sel do not affect the result.
- NAND is the bitwise inverse of AND across all WIDTH bits. No carries; no width growth.
- A requester must drop req by the edge that ends its gnt cycle. If req is still high when the FSM next reaches IDLE, that is treated as a new request.

## Timing
- Reset (rst_n low, asynchronous), all forced immediately:
  - state=IDLE, rr_ptr=0.
  - gnt=0, res_valid=0, res_data=0, res_id=0, busy=0.
  - Any in-flight operation is discarded; no response is produced for it.
- Reset release: the first capture can occur at the first rising edge after rst_n goes high.
- Latency:
  - req sampled at edge N.
  - gnt is high during cycle N..N+1.
  - res_valid rises after edge N+1.
- Throughput: with res_ready held high, one operation per 3 cycles. The sequence is capture (N), result (N+1), accept (N+2), then IDLE for one cycle, so the next capture is at N+3.
- Backpressure: RESP is held for as many cycles as res_ready stays low. busy stays high throughout.
- gnt and res_valid are never high in the same cycle.
- busy = (state != IDLE), driven from registers.

## Test plan
- Single requester 0, op_a=2'b11, op_b=2'b01, op_sel=00:
  - gnt=4'b0001 for one cycle, one cycle after req is sampled.
  - Next cycle: res_valid=1, res_data=2'b01, res_id=0.
- All four requesters held high, res_ready=1, after reset:
  - Grant order 0,1,2,3,0 (pointer wrap).
  - Each grant is a single one-hot pulse, 3 cycles apart.
- Opcode sweep on requester 2, op_a=2'b10, op_b=2'b11:
  - AND gives 2'b10; OR gives 2'b11; XOR gives 2'b01; NAND gives 2'b01.
  - res_id=2 in every case.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid rises.
  - res_data and res_id stay stable; busy=1; a new req on requester 1 gets no gnt.
  - Release res_ready: requester 1 is granted.
- Reset mid-RESP: assert rst_n=0 while res_valid=1.
  - res_valid, gnt and busy go to 0 immediately.
  - After release, requester 3 alone is granted first (rr_ptr=0 search reaches 3).
- Operand change after grant: on requester 1, change op_a during EXEC.
  - res_data reflects the operands captured at the IDLE edge, not the new value.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
// Bundle of request, operand, grant and response signals between the client
// blocks (master) and the shared logic-unit arbiter (slave).
interface logic_unit_arbiter_if #(
  parameter int WIDTH   = 2,
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] op_a;
  logic [NUM_REQ*WIDTH-1:0] op_b;
  logic [NUM_REQ*2-1:0]     op_sel;
  logic [NUM_REQ-1:0]       gnt;
  logic                     res_valid;
  logic [WIDTH-1:0]         res_data;
  logic [IDW-1:0]           res_id;
  logic                     res_ready;
  logic                     busy;

  modport master (
    output req, op_a, op_b, op_sel, res_ready,
    input  gnt, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req, op_a, op_b, op_sel, res_ready,
    output gnt, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one registered bitwise logic unit
// (AND/OR/XOR/NAND) among NUM_REQ requesters and returns tagged results.
module logic_unit_arbiter #(
  parameter int WIDTH   = 2,
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} op_e;

  state_e               state, state_nxt;
  logic [IDW-1:0]       rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]       winner;
  logic                 winner_found;
  logic [IDW:0]         cand;
  logic                 capture, launch, accept;

  logic [WIDTH-1:0]     cap_a, cap_b;
  op_e                  cap_op;
  logic [IDW-1:0]       cap_id;
  logic [WIDTH-1:0]     alu_out;

  logic [NUM_REQ-1:0]   gnt_q;
  logic                 res_valid_q;
  logic [WIDTH-1:0]     res_data_q;
  logic [IDW-1:0]       res_id_q;

  // Search starts at rr_ptr and wraps; cand is one bit wider so ptr+off
  // cannot overflow before the modulo correction.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!winner_found && bus.req[cand[IDW-1:0]]) begin
        winner       = cand[IDW-1:0];
        winner_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    capture    = 1'b0;
    launch     = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (winner_found) begin
          capture    = 1'b1;
          state_nxt  = EXEC;
          rr_ptr_nxt = (winner == IDW'(NUM_REQ-1)) ? '0 : winner + IDW'(1);
        end
      end
      EXEC: begin
        launch    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    alu_out = '0;
    unique case (cap_op)
      OP_AND:  alu_out = cap_a & cap_b;
      OP_OR:   alu_out = cap_a | cap_b;
      OP_XOR:  alu_out = cap_a ^ cap_b;
      OP_NAND: alu_out = ~(cap_a & cap_b);
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand capture registers are reset as well; they are only a
    // few flops and this keeps an aborted operation from leaking afterwards.
    if (!rst_n) begin
      gnt_q       <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      cap_op      <= OP_AND;
      cap_id      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      gnt_q <= capture ? (NUM_REQ'(1) << winner) : '0;
      if (capture) begin
        cap_a  <= bus.op_a[winner*WIDTH +: WIDTH];
        cap_b  <= bus.op_b[winner*WIDTH +: WIDTH];
        cap_op <= op_e'(bus.op_sel[winner*2 +: 2]);
        cap_id <= winner;
      end
      if (launch) begin
        res_valid_q <= 1'b1;
        res_data_q  <= alu_out;
        res_id_q    <= cap_id;
      end else if (accept) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state != IDLE);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_gnt_res_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !((|gnt_q) && res_valid_q));
  a_res_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid_q && !bus.res_ready) |=>
      (res_valid_q && $stable(res_data_q) && $stable(res_id_q)));
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed vector table, corner
// sequences and a randomized run against a transaction-level model.
module tb_logic_unit_arbiter;
  localparam int WIDTH   = 2;
  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic_unit_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  logic_unit_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int overlap_cnt = 0;
  int onehot_bad  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if ((|bus.gnt) && bus.res_valid) overlap_cnt++;
      if ($countones(bus.gnt) > 1) onehot_bad++;
    end
  end

  // Reference: each result bit is decided by how many input bits are set.
  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] sel);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]);
      case (sel)
        2'd0: r[i] = (ones == 2);
        2'd1: r[i] = (ones >= 1);
        2'd2: r[i] = (ones == 1);
        default: r[i] = (ones != 2);
      endcase
    end
    return r;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] mask);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic set_ops(input int id, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [1:0] sel);
    bus.op_a[id*WIDTH +: WIDTH] = a;
    bus.op_b[id*WIDTH +: WIDTH] = b;
    bus.op_sel[id*2 +: 2]       = sel;
  endtask

  task automatic reset_dut();
    bus.req       = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sel    = '0;
    bus.res_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single-requester transaction with res_ready held high.
  task automatic do_txn(input int id, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [1:0] sel,
                        input logic [WIDTH-1:0] exp, input string tag);
    bus.req = '0;
    bus.req[id] = 1'b1;
    set_ops(id, a, b, sel);
    bus.res_ready = 1'b1;
    step();
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(1) << id);
    check({tag, ".valid_in_exec"}, 32'(bus.res_valid), 32'd0);
    check({tag, ".busy_exec"}, 32'(bus.busy), 32'd1);
    bus.req = '0;
    step();
    check({tag, ".gnt_drop"}, 32'(bus.gnt), 32'd0);
    check({tag, ".valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, ".data"}, 32'(bus.res_data), 32'(exp));
    check({tag, ".id"}, 32'(bus.res_id), 32'(id));
    step();
    check({tag, ".valid_clr"}, 32'(bus.res_valid), 32'd0);
    check({tag, ".busy_clr"}, 32'(bus.busy), 32'd0);
  endtask

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    int seen_id[$];
    int seen_cyc[$];
    int ptr;
    logic [WIDTH-1:0] exp_d;
    logic [WIDTH-1:0] hold_d;
    logic [NUM_REQ-1:0] mask;

    vecs[0] = '{id: 0, a: 2'b11, b: 2'b01, sel: 2'b00, exp: 2'b01};
    vecs[1] = '{id: 2, a: 2'b10, b: 2'b11, sel: 2'b00, exp: 2'b10};
    vecs[2] = '{id: 2, a: 2'b10, b: 2'b11, sel: 2'b01, exp: 2'b11};
    vecs[3] = '{id: 2, a: 2'b10, b: 2'b11, sel: 2'b10, exp: 2'b01};
    vecs[4] = '{id: 2, a: 2'b10, b: 2'b11, sel: 2'b11, exp: 2'b01};
    vecs[5] = '{id: 1, a: 2'b01, b: 2'b10, sel: 2'b01, exp: 2'b11};
    vecs[6] = '{id: 3, a: 2'b00, b: 2'b00, sel: 2'b11, exp: 2'b11};
    vecs[7] = '{id: 3, a: 2'b11, b: 2'b11, sel: 2'b10, exp: 2'b00};

    bus.req = '0; bus.op_a = '0; bus.op_b = '0; bus.op_sel = '0;
    bus.res_ready = 1'b1;
    step();
    check("rst.gnt", 32'(bus.gnt), 32'd0);
    check("rst.valid", 32'(bus.res_valid), 32'd0);
    check("rst.data", 32'(bus.res_data), 32'd0);
    check("rst.id", 32'(bus.res_id), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    step();
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      do_txn(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sel, vecs[v].exp,
             $sformatf("vec%0d", v));

    // All requesters held high: grants rotate 0,1,2,3,0 every 3 cycles.
    reset_dut();
    bus.req = '1;
    for (int c = 0; c < 15; c++) begin
      step();
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.gnt[i]) begin
          seen_id.push_back(i);
          seen_cyc.push_back(c);
        end
    end
    bus.req = '0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr.order%0d", k),
            32'(k < seen_id.size() ? seen_id[k] : -1), 32'(k % NUM_REQ));
      if (k > 0)
        check($sformatf("rr.spacing%0d", k),
              32'(k < seen_cyc.size() ? seen_cyc[k] - seen_cyc[k-1] : -1), 32'd3);
    end
    step();
    step();

    // Backpressure: RESP held for 5 cycles; requester 1 must wait.
    bus.res_ready = 1'b0;
    bus.req = 4'b0001;
    set_ops(0, 2'b10, 2'b01, 2'b01);
    step();
    check("bp.gnt0", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    step();
    check("bp.valid", 32'(bus.res_valid), 32'd1);
    bus.req = 4'b0010;
    set_ops(1, 2'b11, 2'b10, 2'b10);
    for (int j = 0; j < 5; j++) begin
      step();
      check($sformatf("bp.hold_valid%0d", j), 32'(bus.res_valid), 32'd1);
      check($sformatf("bp.hold_data%0d", j), 32'(bus.res_data), 32'b11);
      check($sformatf("bp.hold_id%0d", j), 32'(bus.res_id), 32'd0);
      check($sformatf("bp.busy%0d", j), 32'(bus.busy), 32'd1);
      check($sformatf("bp.no_gnt%0d", j), 32'(bus.gnt), 32'd0);
    end
    bus.res_ready = 1'b1;
    step();
    check("bp.accept", 32'(bus.res_valid), 32'd0);
    step();
    check("bp.gnt1", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    step();
    check("bp.data1", 32'(bus.res_data), 32'b01);
    check("bp.id1", 32'(bus.res_id), 32'd1);
    step();

    // Reset while a response is pending.
    bus.res_ready = 1'b0;
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    step();
    check("rr_mid.valid_before", 32'(bus.res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.valid", 32'(bus.res_valid), 32'd0);
    check("rst_mid.gnt", 32'(bus.gnt), 32'd0);
    check("rst_mid.busy", 32'(bus.busy), 32'd0);
    check("rst_mid.data", 32'(bus.res_data), 32'd0);
    step();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    bus.req = 4'b1000;
    set_ops(3, 2'b01, 2'b11, 2'b00);
    step();
    check("rst_mid.gnt3", 32'(bus.gnt), 32'b1000);
    bus.req = '0;
    step();
    check("rst_mid.id3", 32'(bus.res_id), 32'd3);
    check("rst_mid.data3", 32'(bus.res_data), 32'b01);
    step();

    // Operands change after capture: result must use the captured ones.
    bus.req = 4'b0010;
    set_ops(1, 2'b01, 2'b11, 2'b00);
    step();
    check("opchg.gnt", 32'(bus.gnt), 32'b0010);
    set_ops(1, 2'b00, 2'b00, 2'b11);
    bus.req = '0;
    step();
    check("opchg.data", 32'(bus.res_data), 32'b01);
    step();

    // Randomized traffic against the transaction-level model.
    reset_dut();
    ptr = 0;
    for (int t = 0; t < 150; t++) begin
      int w;
      int k;
      mask = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      bus.op_a   = (NUM_REQ*WIDTH)'($urandom);
      bus.op_b   = (NUM_REQ*WIDTH)'($urandom);
      bus.op_sel = (NUM_REQ*2)'($urandom);
      bus.res_ready = 1'b1;
      bus.req = mask;
      w = rr_pick(ptr, mask);
      exp_d = '0;
      if (w >= 0)
        exp_d = ref_op(bus.op_a[w*WIDTH +: WIDTH], bus.op_b[w*WIDTH +: WIDTH],
                       bus.op_sel[w*2 +: 2]);
      step();
      if (w < 0) begin
        check($sformatf("rnd%0d.idle_gnt", t), 32'(bus.gnt), 32'd0);
        check($sformatf("rnd%0d.idle_busy", t), 32'(bus.busy), 32'd0);
        continue;
      end
      check($sformatf("rnd%0d.gnt", t), 32'(bus.gnt), 32'(1) << w);
      ptr = (w + 1) % NUM_REQ;
      bus.req  = '0;
      bus.op_a = (NUM_REQ*WIDTH)'($urandom);
      bus.op_sel = (NUM_REQ*2)'($urandom);
      k = $urandom_range(0, 3);
      bus.res_ready = (k == 0);
      step();
      check($sformatf("rnd%0d.valid", t), 32'(bus.res_valid), 32'd1);
      check($sformatf("rnd%0d.data", t), 32'(bus.res_data), 32'(exp_d));
      check($sformatf("rnd%0d.id", t), 32'(bus.res_id), 32'(w));
      hold_d = exp_d;
      for (int j = 0; j < k; j++) begin
        bus.req = NUM_REQ'($urandom);
        step();
        check($sformatf("rnd%0d.hold%0d", t, j), 32'(bus.res_data), 32'(hold_d));
        check($sformatf("rnd%0d.hold_v%0d", t, j), 32'(bus.res_valid), 32'd1);
        check($sformatf("rnd%0d.hold_g%0d", t, j), 32'(bus.gnt), 32'd0);
      end
      bus.req = '0;
      bus.res_ready = 1'b1;
      step();
      check($sformatf("rnd%0d.done", t), 32'(bus.res_valid), 32'd0);
      check($sformatf("rnd%0d.done_busy", t), 32'(bus.busy), 32'd0);
    end

    check("gnt_res_overlap", 32'(overlap_cnt), 32'd0);
    check("gnt_onehot", 32'(onehot_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
